// File: rtl/vga_crtc.sv
// 640x400@70Hz text-mode CRT timing: 80x25 cells of 8x16, 32 clk per column; CRTC_CURSOR_BLINK_EN enables cursor blink.
// Latency: every output is a combinational decode of the counters, so an output changes in the same cycle as the counters.
// Backpressure: none. The counters run freely and cannot be stalled.
module vga_crtc #(
  parameter int H_VIS        = 80,
  parameter int H_FP         = 2,
  parameter int H_SYNC       = 12,
  parameter int H_TOT        = 100,
  parameter int V_VIS        = 400,
  parameter int V_FP         = 12,
  parameter int V_SYNC       = 2,
  parameter int V_TOT        = 449,
  parameter int CLK_PER_COL  = 32,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic       col_stb_o,
  output logic [6:0] col_o,
  output logic [8:0] line_o,
  output logic       cursor_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o
);

  localparam int DIV_W = (CLK_PER_COL > 1) ? $clog2(CLK_PER_COL) : 1;

  localparam logic [6:0] HS_FIRST = 7'(H_VIS + H_FP);
  localparam logic [6:0] HS_LAST  = 7'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [8:0] VS_FIRST = 9'(V_VIS + V_FP);
  localparam logic [8:0] VS_LAST  = 9'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q;
  logic             div_last;
  logic             col_last;
  logic             line_last;
  logic             line_end;
  logic             frame_end;
  logic             blink_on;

  assign div_last  = (div_q == DIV_W'(CLK_PER_COL - 1));
  assign col_last  = (col_o == 7'(H_TOT - 1));
  assign line_last = (line_o == 9'(V_TOT - 1));
  assign line_end  = div_last && col_last;
  assign frame_end = line_end && line_last;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      div_q <= '0;
    else if (div_last) div_q <= '0;
    else               div_q <= div_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      col_o <= '0;
    else if (div_last) col_o <= col_last ? 7'd0 : col_o + 7'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      line_o <= '0;
    else if (line_end) line_o <= line_last ? 9'd0 : line_o + 9'd1;
  end

`ifdef CRTC_CURSOR_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_q;

  // Blink phase flips at the end of the last frame of each half-period.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_q  <= '0;
      blink_on <= 1'b1;
    end else if (frame_end) begin
      if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_q  <= '0;
        blink_on <= ~blink_on;
      end else begin
        frame_q  <= frame_q + 1'b1;
      end
    end
  end
`else
  logic unused_blink_cfg;

  assign blink_on         = 1'b1;
  assign unused_blink_cfg = frame_end ^ (BLINK_FRAMES != 0);
`endif

  assign col_stb_o  = (div_q == '0);
  assign hsync_o    = !((col_o >= HS_FIRST) && (col_o <= HS_LAST));
  assign vsync_o    = (line_o >= VS_FIRST) && (line_o <= VS_LAST);
  assign video_on_o = (col_o < 7'(H_VIS)) && (line_o < 9'(V_VIS));
  // Underline on the bottom two scanlines of every 16-line cell.
  assign cursor_o   = video_on_o && (line_o[3:0] >= 4'd14) && blink_on;

endmodule

// File: tb/tb_vga_crtc.sv
// Directed bench for vga_crtc: full-size timing plus a scaled instance for frame, vsync and blink.
module tb_vga_crtc;

  typedef struct packed {
    logic [31:0] clk;
    logic        stb;
    logic [6:0]  col;
    logic [8:0]  line;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        cur;
  } vec_t;

`ifdef CRTC_CURSOR_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       d_stb, d_cur, d_hs, d_vs, d_vid;
  logic [6:0] d_col;
  logic [8:0] d_line;
  logic       s_stb, s_cur, s_hs, s_vs, s_vid;
  logic [6:0] s_col;
  logic [8:0] s_line;

  int vectors;
  int miscompares;
  int cyc;

  vga_crtc u_dflt (
    .clk_i(clk), .rst_n_i(rst_n), .col_stb_o(d_stb), .col_o(d_col), .line_o(d_line),
    .cursor_o(d_cur), .hsync_o(d_hs), .vsync_o(d_vs), .video_on_o(d_vid)
  );

  // Scaled geometry: 4 clk/col, 8 cols/line (hsync cols 5-6), 24 lines/frame (vsync 18-19).
  vga_crtc #(
    .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_TOT(8),
    .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_TOT(24),
    .CLK_PER_COL(4), .BLINK_FRAMES(2)
  ) u_small (
    .clk_i(clk), .rst_n_i(rst_n), .col_stb_o(s_stb), .col_o(s_col), .line_o(s_line),
    .cursor_o(s_cur), .hsync_o(s_hs), .vsync_o(s_vs), .video_on_o(s_vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam vec_t T_COLSTB [6] = '{
    '{32'd0,  1'b1, 7'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd1,  1'b0, 7'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd31, 1'b0, 7'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd32, 1'b1, 7'd1, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd33, 1'b0, 7'd1, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd64, 1'b1, 7'd2, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0}
  };

  localparam vec_t T_LINE [9] = '{
    '{32'd2559, 1'b0, 7'd79, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd2560, 1'b1, 7'd80, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd2623, 1'b0, 7'd81, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd2624, 1'b1, 7'd82, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'd3007, 1'b0, 7'd93, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'd3008, 1'b1, 7'd94, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd3199, 1'b0, 7'd99, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd3200, 1'b1, 7'd0,  9'd1, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd5824, 1'b1, 7'd82, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0}
  };

  localparam vec_t T_CURSOR [7] = '{
    '{32'd44799, 1'b0, 7'd99, 9'd13, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd44800, 1'b1, 7'd0,  9'd14, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd47359, 1'b0, 7'd79, 9'd14, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd47360, 1'b1, 7'd80, 9'd14, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd48000, 1'b1, 7'd0,  9'd15, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd51199, 1'b0, 7'd99, 9'd15, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd51200, 1'b1, 7'd0,  9'd16, 1'b1, 1'b0, 1'b1, 1'b0}
  };

  localparam vec_t T_FRAME [18] = '{
    '{32'd0,   1'b1, 7'd0, 9'd0,  1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd19,  1'b0, 7'd4, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd20,  1'b1, 7'd5, 9'd0,  1'b0, 1'b0, 1'b0, 1'b0},
    '{32'd27,  1'b0, 7'd6, 9'd0,  1'b0, 1'b0, 1'b0, 1'b0},
    '{32'd28,  1'b1, 7'd7, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd31,  1'b0, 7'd7, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd32,  1'b1, 7'd0, 9'd1,  1'b1, 1'b0, 1'b1, 1'b0},
    '{32'd448, 1'b1, 7'd0, 9'd14, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd492, 1'b1, 7'd3, 9'd15, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd495, 1'b0, 7'd3, 9'd15, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd496, 1'b1, 7'd4, 9'd15, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd512, 1'b1, 7'd0, 9'd16, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd575, 1'b0, 7'd7, 9'd17, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd576, 1'b1, 7'd0, 9'd18, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'd639, 1'b0, 7'd7, 9'd19, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'd640, 1'b1, 7'd0, 9'd20, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd767, 1'b0, 7'd7, 9'd23, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'd768, 1'b1, 7'd0, 9'd0,  1'b1, 1'b0, 1'b1, 1'b0}
  };

  // Line 14, col 0 of frames 1..4; frames 2-3 are the blanked half-period when blinking.
  localparam vec_t T_BLINK [4] = '{
    '{32'd1216, 1'b1, 7'd0, 9'd14, 1'b1, 1'b0, 1'b1, 1'b1},
    '{32'd1984, 1'b1, 7'd0, 9'd14, 1'b1, 1'b0, 1'b1, ~BLINK},
    '{32'd2752, 1'b1, 7'd0, 9'd14, 1'b1, 1'b0, 1'b1, ~BLINK},
    '{32'd3520, 1'b1, 7'd0, 9'd14, 1'b1, 1'b0, 1'b1, 1'b1}
  };

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic goto(input int n);
    if (n > cyc) begin
      repeat (n - cyc) @(posedge clk);
      #1;
      cyc = n;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur} !== {1'b1, 7'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_dflt got stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b want 1/0/0/1/0/1/0",
               d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur);
    end
    vectors++;
    if ({s_stb, s_col, s_line, s_hs, s_vs, s_vid, s_cur} !== {1'b1, 7'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_small got stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b want 1/0/0/1/0/1/0",
               s_stb, s_col, s_line, s_hs, s_vs, s_vid, s_cur);
    end
  endtask

  task automatic test_col_stb();
    do_reset();
    foreach (T_COLSTB[i]) begin
      goto(int'(T_COLSTB[i].clk));
      vectors++;
      if ({d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur} !== {T_COLSTB[i].stb, T_COLSTB[i].col, T_COLSTB[i].line,
          T_COLSTB[i].hs, T_COLSTB[i].vs, T_COLSTB[i].vid, T_COLSTB[i].cur}) begin
        miscompares++;
        $display("FAIL col_stb clk=%0d got stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b want stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b",
                 cyc, d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur, T_COLSTB[i].stb, T_COLSTB[i].col,
                 T_COLSTB[i].line, T_COLSTB[i].hs, T_COLSTB[i].vs, T_COLSTB[i].vid, T_COLSTB[i].cur);
      end
    end
  endtask

  task automatic test_line_timing();
    do_reset();
    foreach (T_LINE[i]) begin
      goto(int'(T_LINE[i].clk));
      vectors++;
      if ({d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur} !== {T_LINE[i].stb, T_LINE[i].col, T_LINE[i].line,
          T_LINE[i].hs, T_LINE[i].vs, T_LINE[i].vid, T_LINE[i].cur}) begin
        miscompares++;
        $display("FAIL line_timing clk=%0d got stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b want stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b",
                 cyc, d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur, T_LINE[i].stb, T_LINE[i].col,
                 T_LINE[i].line, T_LINE[i].hs, T_LINE[i].vs, T_LINE[i].vid, T_LINE[i].cur);
      end
    end
  endtask

  task automatic test_cursor();
    do_reset();
    foreach (T_CURSOR[i]) begin
      goto(int'(T_CURSOR[i].clk));
      vectors++;
      if ({d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur} !== {T_CURSOR[i].stb, T_CURSOR[i].col, T_CURSOR[i].line,
          T_CURSOR[i].hs, T_CURSOR[i].vs, T_CURSOR[i].vid, T_CURSOR[i].cur}) begin
        miscompares++;
        $display("FAIL cursor clk=%0d got stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b want stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b",
                 cyc, d_stb, d_col, d_line, d_hs, d_vs, d_vid, d_cur, T_CURSOR[i].stb, T_CURSOR[i].col,
                 T_CURSOR[i].line, T_CURSOR[i].hs, T_CURSOR[i].vs, T_CURSOR[i].vid, T_CURSOR[i].cur);
      end
    end
  endtask

  task automatic test_frame();
    do_reset();
    foreach (T_FRAME[i]) begin
      goto(int'(T_FRAME[i].clk));
      vectors++;
      if ({s_stb, s_col, s_line, s_hs, s_vs, s_vid, s_cur} !== {T_FRAME[i].stb, T_FRAME[i].col, T_FRAME[i].line,
          T_FRAME[i].hs, T_FRAME[i].vs, T_FRAME[i].vid, T_FRAME[i].cur}) begin
        miscompares++;
        $display("FAIL frame clk=%0d got stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b want stb=%b col=%0d line=%0d hs=%b vs=%b vid=%b cur=%b",
                 cyc, s_stb, s_col, s_line, s_hs, s_vs, s_vid, s_cur, T_FRAME[i].stb, T_FRAME[i].col,
                 T_FRAME[i].line, T_FRAME[i].hs, T_FRAME[i].vs, T_FRAME[i].vid, T_FRAME[i].cur);
      end
    end
  endtask

  task automatic test_blink();
    do_reset();
    foreach (T_BLINK[i]) begin
      goto(int'(T_BLINK[i].clk));
      vectors++;
      if ({s_stb, s_col, s_line, s_hs, s_vs, s_vid, s_cur} !== {T_BLINK[i].stb, T_BLINK[i].col, T_BLINK[i].line,
          T_BLINK[i].hs, T_BLINK[i].vs, T_BLINK[i].vid, T_BLINK[i].cur}) begin
        miscompares++;
        $display("FAIL blink clk=%0d got stb=%b col=%0d line=%0d vid=%b cur=%b want stb=%b col=%0d line=%0d vid=%b cur=%b",
                 cyc, s_stb, s_col, s_line, s_vid, s_cur, T_BLINK[i].stb, T_BLINK[i].col,
                 T_BLINK[i].line, T_BLINK[i].vid, T_BLINK[i].cur);
      end
    end
  endtask

  // Reset lands between clock edges, mid-line and (scaled) inside the blanked blink phase.
  task automatic test_mid_reset();
    do_reset();
    goto(1985);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({d_stb, d_col, d_line, d_hs, d_vid, s_stb, s_col, s_line, s_vs, s_cur} !==
        {1'b1, 7'd0, 9'd0, 1'b1, 1'b1, 1'b1, 7'd0, 9'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset got d_stb=%b d_col=%0d d_line=%0d d_hs=%b d_vid=%b s_stb=%b s_col=%0d s_line=%0d s_vs=%b s_cur=%b want 1/0/0/1/1/1/0/0/0/0",
               d_stb, d_col, d_line, d_hs, d_vid, s_stb, s_col, s_line, s_vs, s_cur);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    goto(32);
    vectors++;
    if ({d_stb, d_col, d_line} !== {1'b1, 7'd1, 9'd0}) begin
      miscompares++;
      $display("FAIL mid_reset_restart got stb=%b col=%0d line=%0d want stb=1 col=1 line=0", d_stb, d_col, d_line);
    end
    goto(448);
    vectors++;
    if ({s_line, s_col, s_cur} !== {9'd14, 7'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_blink got line=%0d col=%0d cur=%b want line=14 col=0 cur=1", s_line, s_col, s_cur);
    end
    vectors++;
    if ({d_col, d_line, d_stb} !== {7'd14, 9'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_dflt got col=%0d line=%0d stb=%b want col=14 line=0 stb=1", d_col, d_line, d_stb);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b1;
    test_reset();
    test_col_stb();
    test_line_timing();
    test_cursor();
    test_frame();
    test_blink();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
